wishbone_req_router: RTL and testbench
======================================

Name: wishbone_req_router

Overview:
Request-side companion to the Wishbone response multiplexer. It accepts single Wishbone classic cycles from the Caravel management-side master, range-decodes the address, and forwards the cycle to the decoder or RAM target. It registers the target's ack and data back to the master. Unmapped addresses get a deterministic error response, so the bus never hangs.

Parameters:
DEC_BASE, 32'h3000_0000, first decoder address (inclusive)
DEC_LAST, 32'h3000_0019, last decoder address (inclusive)
RAM_BASE, 32'h3000_0100, first RAM address (inclusive)
RAM_LAST, 32'h3000_0119, last RAM address (inclusive)
TIMEOUT_CYCLES, 255, target-wait cycles before forced completion (used only with the optional feature)

Ports:
wb_clk_i  in  1  single clock
wb_rst_i  in  1  synchronous, active-high reset
wbs_cyc_i  in  1  master cycle
wbs_stb_i  in  1  master strobe
wbs_we_i  in  1  write enable
wbs_sel_i  in  4  byte selects
wbs_adr_i  in  32  address
wbs_dat_i  in  32  write data
wbs_ack_o  out  1  one-cycle acknowledge to master
wbs_dat_o  out  32  read data to master
tgt_we_o  out  1  latched we, shared by both targets
tgt_sel_o  out  4  latched sel, shared
tgt_adr_o  out  32  latched address, shared
tgt_dat_o  out  32  latched write data, shared
dec_cyc_o, dec_stb_o  out  1 each  decoder target cycle/strobe
dec_ack_i  in  1  decoder ack
dec_dat_i  in  32  decoder read data
ram_cyc_o, ram_stb_o  out  1 each  RAM target cycle/strobe
ram_ack_i  in  1  RAM ack
ram_dat_i  in  32  RAM read data

Behaviour:
- Reset, sampled on the wb_clk_i edge, clears the state to IDLE. All outputs go to 0: wbs_ack_o, wbs_dat_o, all tgt_*, dec_cyc_o/stb_o, ram_cyc_o/stb_o.
- Reset asserted mid-transaction: targets are released on the next edge and the master receives no ack.
- FSM states are IDLE, FWD, RESP.
- IDLE:
  - Waits for wbs_cyc_i & wbs_stb_i & ~wbs_ack_o.
  - On acceptance, latches adr/dat/we/sel into tgt_*.
  - Decoder hit: asserts dec_cyc_o/dec_stb_o, goes to FWD.
  - RAM hit: asserts ram_cyc_o/ram_stb_o, goes to FWD.
  - Miss: loads wbs_dat_o = 32'hBADA_DD00, goes to RESP.
- Decode is inclusive on both bounds: BASE <= adr <= LAST, unsigned 32-bit. Decoder range takes priority if the ranges ever overlap.
- FWD:
  - Target strobe stays high until the selected target's ack is sampled high.
  - The ack of the unselected target is ignored.
  - On ack: drop the target cyc/stb, capture the selected target's data into wbs_dat_o, go to RESP.
  - A write captures target data unchanged; the master ignores it.
- RESP: wbs_ack_o = 1 for exactly one cycle, then return to IDLE. wbs_dat_o holds its value until the next capture.
- Latency:
  - Master strobe seen at edge N.
  - Target strobe is high after N.
  - Target ack seen at edge M.
  - wbs_ack_o is high for the cycle after M.
  - Minimum total latency is 3 cycles (target acks in the first cycle); unmapped addresses take 2 cycles.
- Abort: wbs_cyc_i low in FWD releases the target at the next edge and returns to IDLE with no ack. A late target ack is ignored in IDLE.
- Back-to-back cycles: the master strobe held through the ack cycle is not re-accepted, because of the ~wbs_ack_o gate. A fresh strobe in the cycle after the ack is accepted.

Optional Feature:
WB_ROUTER_TIMEOUT_EN
- Defined:
  - An 8-bit-or-wider counter clears on entry to FWD and increments each FWD cycle.
  - When it reaches TIMEOUT_CYCLES with no ack, the target is released, wbs_dat_o = 32'hDEAD_0000, and the FSM goes to RESP.
  - An ack arriving in the same cycle as the timeout wins.
- Undefined: no counter; FWD waits indefinitely.

Decomposition:
- Package wb_router_pkg holds:
  - state encoding
  - default range constants
  - MISS_DATA = 32'hBADA_DD00
  - TIMEOUT_DATA = 32'hDEAD_0000
- One combinational sub-module, wb_addr_decode: takes the address, outputs one-hot {hit_dec, hit_ram, miss}. It is reused by the response multiplexer later.

Test Plan:
- Read adr 30000004; decoder acks after 2 cycles with 0x1234_5678 -> dec_stb_o high for 2 cycles, wbs_ack_o one cycle later, wbs_dat_o=0x1234_5678, ram_stb_o never high.
- Write adr 30000110, dat 0xA5A5_A5A5, sel 4'b0011 -> ram_stb_o high, tgt_dat_o=0xA5A5_A5A5, tgt_sel_o=4'b0011, tgt_we_o=1, single wbs_ack_o.
- Boundaries: adr 30000019 -> decoder; 3000001A -> miss, ack after 2 cycles, data 0xBADA_DD00; 300000FF -> miss; 30000100 -> RAM.
- Abort: wbs_cyc_i dropped 1 cycle into FWD -> target strobe low next cycle, no wbs_ack_o; a later ram_ack_i pulse is ignored.
- wb_rst_i pulsed while in FWD -> all outputs 0 the next cycle; a new read afterwards completes normally.
- With WB_ROUTER_TIMEOUT_EN and TIMEOUT_CYCLES=4, a target that never acks -> ack after the 4th FWD cycle with data 0xDEAD_0000. Without the macro, the bus stays waiting for 50 cycles.

Source files
------------

// File: rtl/wb_router_pkg.sv
// Shared types and constants for the Wishbone request router and its address decoder.
// The optional timeout feature is enabled with `define WB_ROUTER_TIMEOUT_EN.
package wb_router_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FWD  = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    localparam logic [31:0] DEF_DEC_BASE = 32'h3000_0000;
    localparam logic [31:0] DEF_DEC_LAST = 32'h3000_0019;
    localparam logic [31:0] DEF_RAM_BASE = 32'h3000_0100;
    localparam logic [31:0] DEF_RAM_LAST = 32'h3000_0119;

    // Read data returned for unmapped addresses and for timed-out targets.
    localparam logic [31:0] MISS_DATA    = 32'hBADA_DD00;
    localparam logic [31:0] TIMEOUT_DATA = 32'hDEAD_0000;

endpackage

// File: rtl/wb_addr_decode.sv
// Inclusive range decode of a Wishbone address into one-hot {hit_dec, hit_ram, miss}.
// The decoder range wins where the two ranges overlap.
module wb_addr_decode
    import wb_router_pkg::*;
#(
    parameter logic [31:0] DEC_BASE = DEF_DEC_BASE,
    parameter logic [31:0] DEC_LAST = DEF_DEC_LAST,
    parameter logic [31:0] RAM_BASE = DEF_RAM_BASE,
    parameter logic [31:0] RAM_LAST = DEF_RAM_LAST
) (
    input  logic [31:0] adr_i,
    output logic        hit_dec_o,
    output logic        hit_ram_o,
    output logic        miss_o
);

    logic in_dec;
    logic in_ram;

    assign in_dec    = (adr_i >= DEC_BASE) && (adr_i <= DEC_LAST);
    assign in_ram    = (adr_i >= RAM_BASE) && (adr_i <= RAM_LAST);
    assign hit_dec_o = in_dec;
    assign hit_ram_o = in_ram && !in_dec;
    assign miss_o    = !in_dec && !in_ram;

endmodule

// File: rtl/wishbone_req_router.sv
// Routes single Wishbone classic cycles to the decoder or RAM target and registers the response.
// `define WB_ROUTER_TIMEOUT_EN adds a forced completion after TIMEOUT_CYCLES target-wait cycles.
module wishbone_req_router
    import wb_router_pkg::*;
#(
    parameter logic [31:0] DEC_BASE = DEF_DEC_BASE,
    parameter logic [31:0] DEC_LAST = DEF_DEC_LAST,
    parameter logic [31:0] RAM_BASE = DEF_RAM_BASE,
    parameter logic [31:0] RAM_LAST = DEF_RAM_LAST,
    parameter int          TIMEOUT_CYCLES = 255
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    output logic        tgt_we_o,
    output logic [3:0]  tgt_sel_o,
    output logic [31:0] tgt_adr_o,
    output logic [31:0] tgt_dat_o,
    output logic        dec_cyc_o,
    output logic        dec_stb_o,
    input  logic        dec_ack_i,
    input  logic [31:0] dec_dat_i,
    output logic        ram_cyc_o,
    output logic        ram_stb_o,
    input  logic        ram_ack_i,
    input  logic [31:0] ram_dat_i
);

    logic hit_dec, hit_ram, miss;

    wb_addr_decode #(
        .DEC_BASE (DEC_BASE),
        .DEC_LAST (DEC_LAST),
        .RAM_BASE (RAM_BASE),
        .RAM_LAST (RAM_LAST)
    ) u_decode (
        .adr_i     (wbs_adr_i),
        .hit_dec_o (hit_dec),
        .hit_ram_o (hit_ram),
        .miss_o    (miss)
    );

    state_e      state_q;
    logic        ack_q;
    logic [31:0] rdat_q;
    logic        we_q;
    logic [3:0]  sel_q;
    logic [31:0] adr_q;
    logic [31:0] wdat_q;
    logic        dec_cyc_q;
    logic        ram_cyc_q;

`ifdef WB_ROUTER_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYCLES > 255) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
    logic [CNT_W-1:0] cnt_q;
`endif

    // Only one target is ever active in FWD, so its cyc bit selects the response path.
    logic        tgt_ack;
    logic [31:0] tgt_rdat;
    assign tgt_ack  = dec_cyc_q ? dec_ack_i : ram_ack_i;
    assign tgt_rdat = dec_cyc_q ? dec_dat_i : ram_dat_i;

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q   <= ST_IDLE;
            ack_q     <= 1'b0;
            rdat_q    <= '0;
            we_q      <= 1'b0;
            sel_q     <= '0;
            adr_q     <= '0;
            wdat_q    <= '0;
            dec_cyc_q <= 1'b0;
            ram_cyc_q <= 1'b0;
`ifdef WB_ROUTER_TIMEOUT_EN
            cnt_q     <= '0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    ack_q <= 1'b0;
                    if (wbs_cyc_i && wbs_stb_i && !ack_q) begin
                        we_q   <= wbs_we_i;
                        sel_q  <= wbs_sel_i;
                        adr_q  <= wbs_adr_i;
                        wdat_q <= wbs_dat_i;
`ifdef WB_ROUTER_TIMEOUT_EN
                        cnt_q  <= '0;
`endif
                        if (hit_dec) begin
                            dec_cyc_q <= 1'b1;
                            state_q   <= ST_FWD;
                        end else if (hit_ram) begin
                            ram_cyc_q <= 1'b1;
                            state_q   <= ST_FWD;
                        end else if (miss) begin
                            rdat_q  <= MISS_DATA;
                            ack_q   <= 1'b1;
                            state_q <= ST_RESP;
                        end
                    end
                end
                ST_FWD: begin
                    // A master abort takes precedence: no ack is owed once cyc drops.
                    if (!wbs_cyc_i) begin
                        dec_cyc_q <= 1'b0;
                        ram_cyc_q <= 1'b0;
                        state_q   <= ST_IDLE;
                    end else if (tgt_ack) begin
                        dec_cyc_q <= 1'b0;
                        ram_cyc_q <= 1'b0;
                        rdat_q    <= tgt_rdat;
                        ack_q     <= 1'b1;
                        state_q   <= ST_RESP;
                    end
`ifdef WB_ROUTER_TIMEOUT_EN
                    else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        dec_cyc_q <= 1'b0;
                        ram_cyc_q <= 1'b0;
                        rdat_q    <= TIMEOUT_DATA;
                        ack_q     <= 1'b1;
                        state_q   <= ST_RESP;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
`endif
                end
                ST_RESP: begin
                    ack_q   <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign wbs_ack_o = ack_q;
    assign wbs_dat_o = rdat_q;
    assign tgt_we_o  = we_q;
    assign tgt_sel_o = sel_q;
    assign tgt_adr_o = adr_q;
    assign tgt_dat_o = wdat_q;
    assign dec_cyc_o = dec_cyc_q;
    assign dec_stb_o = dec_cyc_q;
    assign ram_cyc_o = ram_cyc_q;
    assign ram_stb_o = ram_cyc_q;

endmodule

// File: tb/tb_wishbone_req_router.sv
// Directed-vector bench for wishbone_req_router: decode boundaries, latency, abort, reset, hang/timeout.
module tb_wishbone_req_router;

    logic        clk = 1'b0;
    logic        rst;
    logic        cyc, stb, we;
    logic [3:0]  sel;
    logic [31:0] adr, wdat;
    logic        ack;
    logic [31:0] rdat;
    logic        t_we;
    logic [3:0]  t_sel;
    logic [31:0] t_adr, t_dat;
    logic        d_cyc, d_stb, d_ack;
    logic [31:0] d_dat;
    logic        r_cyc, r_stb, r_ack;
    logic [31:0] r_dat;

    always #5 clk = ~clk;

    wishbone_req_router #(.TIMEOUT_CYCLES(4)) dut (
        .wb_clk_i (clk),   .wb_rst_i (rst),
        .wbs_cyc_i(cyc),   .wbs_stb_i(stb),   .wbs_we_i(we),
        .wbs_sel_i(sel),   .wbs_adr_i(adr),   .wbs_dat_i(wdat),
        .wbs_ack_o(ack),   .wbs_dat_o(rdat),
        .tgt_we_o (t_we),  .tgt_sel_o(t_sel), .tgt_adr_o(t_adr), .tgt_dat_o(t_dat),
        .dec_cyc_o(d_cyc), .dec_stb_o(d_stb), .dec_ack_i(d_ack), .dec_dat_i(d_dat),
        .ram_cyc_o(r_cyc), .ram_stb_o(r_stb), .ram_ack_i(r_ack), .ram_dat_i(r_dat)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Results of the last xfer: latency in cycles counting the cycle the master drives,
    // target strobe cycles seen, returned data and a snapshot of the tgt_* bus.
    int          x_lat, x_dstb, x_rstb;
    logic [31:0] x_dat, s_adr, s_dat;
    logic [3:0]  s_sel;
    logic        s_we;

    // Drives one master cycle and plays both targets; ack_dly=0 means the target never acks.
    // With noise set, the unselected target acks with junk data every strobe cycle.
    task automatic xfer(input logic [31:0] a, input logic w, input logic [31:0] wd, input logic [3:0] s,
                        input int ack_dly, input logic [31:0] tdat, input bit noise, input int maxt);
        cyc = 1'b1; stb = 1'b1; adr = a; we = w; wdat = wd; sel = s;
        x_lat = -1; x_dstb = 0; x_rstb = 0; x_dat = 32'hx;
        for (int i = 0; i < maxt; i++) begin
            tick();
            d_ack = 1'b0; r_ack = 1'b0; d_dat = '0; r_dat = '0;
            if (ack) begin
                x_lat = i + 2;
                x_dat = rdat;
                break;
            end
            if (d_stb || r_stb) begin
                s_adr = t_adr; s_dat = t_dat; s_sel = t_sel; s_we = t_we;
            end
            if (d_stb) begin
                x_dstb++;
                if (x_dstb == ack_dly) begin d_ack = 1'b1; d_dat = tdat; end
                if (noise) begin r_ack = 1'b1; r_dat = 32'hFFFF_FFFF; end
            end
            if (r_stb) begin
                x_rstb++;
                if (x_rstb == ack_dly) begin r_ack = 1'b1; r_dat = tdat; end
                if (noise) begin d_ack = 1'b1; d_dat = 32'hFFFF_FFFF; end
            end
        end
    endtask

    // Master releases the bus after the ack cycle; the ack must have been a single pulse.
    task automatic finish_xfer(input string tag);
        cyc = 1'b0; stb = 1'b0;
        tick();
        chk({tag, "_ack1"}, {31'd0, ack}, 32'd0);
    endtask

    initial begin
        rst = 1'b1; cyc = 0; stb = 0; we = 0; sel = 0; adr = 0; wdat = 0;
        d_ack = 0; d_dat = 0; r_ack = 0; r_dat = 0;
        tick(); tick();
        chk("rst_ctl", {24'd0, ack, d_cyc, d_stb, r_cyc, r_stb, t_we, 2'b00}, 32'd0);
        chk("rst_rdat", rdat, 32'd0);
        chk("rst_tadr", t_adr, 32'd0);
        chk("rst_tdat", {t_dat[31:4], t_dat[3:0] | t_sel}, 32'd0);
        rst = 1'b0;
        tick();

        // Decoder read, ack in 2nd strobe cycle, RAM acking junk throughout.
        xfer(32'h3000_0004, 1'b0, 32'h0, 4'hF, 2, 32'h1234_5678, 1'b1, 20);
        chk("rd_lat", x_lat, 32'd4);
        chk("rd_dstb", x_dstb, 32'd2);
        chk("rd_rstb", x_rstb, 32'd0);
        chk("rd_dat", x_dat, 32'h1234_5678);
        chk("rd_tadr", s_adr, 32'h3000_0004);
        finish_xfer("rd");
        chk("rd_hold", rdat, 32'h1234_5678);

        // RAM write, ack in first cycle: minimum 3-cycle latency.
        xfer(32'h3000_0110, 1'b1, 32'hA5A5_A5A5, 4'b0011, 1, 32'h0000_5A5A, 1'b0, 20);
        chk("wr_lat", x_lat, 32'd3);
        chk("wr_rstb", x_rstb, 32'd1);
        chk("wr_dstb", x_dstb, 32'd0);
        chk("wr_tdat", s_dat, 32'hA5A5_A5A5);
        chk("wr_tsel", {28'd0, s_sel}, 32'd3);
        chk("wr_twe", {31'd0, s_we}, 32'd1);
        chk("wr_dat", x_dat, 32'h0000_5A5A);
        finish_xfer("wr");

        // Range boundaries.
        xfer(32'h3000_0019, 1'b0, 32'h0, 4'hF, 1, 32'h0000_0019, 1'b1, 20);
        chk("b19_dstb", x_dstb, 32'd1);
        chk("b19_dat", x_dat, 32'h0000_0019);
        finish_xfer("b19");
        xfer(32'h3000_001A, 1'b0, 32'h0, 4'hF, 1, 32'h0, 1'b0, 20);
        chk("b1A_lat", x_lat, 32'd2);
        chk("b1A_stb", x_dstb + x_rstb, 32'd0);
        chk("b1A_dat", x_dat, 32'hBADA_DD00);
        finish_xfer("b1A");
        xfer(32'h3000_00FF, 1'b0, 32'h0, 4'hF, 1, 32'h0, 1'b0, 20);
        chk("bFF_lat", x_lat, 32'd2);
        chk("bFF_dat", x_dat, 32'hBADA_DD00);
        finish_xfer("bFF");
        xfer(32'h3000_0100, 1'b0, 32'h0, 4'hF, 1, 32'h0000_0100, 1'b1, 20);
        chk("b100_rstb", x_rstb, 32'd1);
        chk("b100_dstb", x_dstb, 32'd0);
        chk("b100_dat", x_dat, 32'h0000_0100);
        finish_xfer("b100");
        xfer(32'h3000_0119, 1'b0, 32'h0, 4'hF, 1, 32'h0000_0119, 1'b0, 20);
        chk("b119_rstb", x_rstb, 32'd1);
        finish_xfer("b119");
        xfer(32'h3000_011A, 1'b0, 32'h0, 4'hF, 1, 32'h0, 1'b0, 20);
        chk("b11A_dat", x_dat, 32'hBADA_DD00);
        finish_xfer("b11A");

        // Strobe held through the ack cycle is not re-accepted; the next cycle it is.
        xfer(32'h3000_001A, 1'b0, 32'h0, 4'hF, 1, 32'h0, 1'b0, 20);
        chk("b2b_lat", x_lat, 32'd2);
        adr = 32'h3000_0008;
        tick();
        chk("b2b_noacc", {30'd0, ack, d_stb}, 32'd0);
        tick();
        chk("b2b_acc", {31'd0, d_stb}, 32'd1);
        d_ack = 1'b1; d_dat = 32'h0BB0_0BB0;
        tick();
        d_ack = 1'b0;
        chk("b2b_ack", {31'd0, ack}, 32'd1);
        chk("b2b_dat", rdat, 32'h0BB0_0BB0);
        finish_xfer("b2b");

        // Abort one cycle into FWD; a late RAM ack must be ignored.
        cyc = 1'b1; stb = 1'b1; adr = 32'h3000_0104; we = 1'b0;
        tick();
        chk("ab_fwd", {31'd0, r_stb}, 32'd1);
        cyc = 1'b0; stb = 1'b0;
        tick();
        chk("ab_rel", {30'd0, r_stb, ack}, 32'd0);
        r_ack = 1'b1; r_dat = 32'hCAFE_F00D;
        tick();
        r_ack = 1'b0;
        tick();
        chk("ab_late", {30'd0, r_stb, ack}, 32'd0);
        chk("ab_dat", rdat, 32'h0BB0_0BB0);

        // Reset while in FWD, then a normal read.
        cyc = 1'b1; stb = 1'b1; adr = 32'h3000_0000;
        tick();
        chk("rf_fwd", {31'd0, d_stb}, 32'd1);
        rst = 1'b1; cyc = 1'b0; stb = 1'b0;
        tick();
        rst = 1'b0;
        chk("rf_ctl", {26'd0, ack, d_cyc, d_stb, r_cyc, r_stb, t_we}, 32'd0);
        chk("rf_data", rdat | t_adr | t_dat | {28'd0, t_sel}, 32'd0);
        xfer(32'h3000_0000, 1'b0, 32'h0, 4'hF, 1, 32'h7777_0000, 1'b0, 20);
        chk("rf_lat", x_lat, 32'd3);
        chk("rf_dat", x_dat, 32'h7777_0000);
        finish_xfer("rf");

        // Target that never acks.
`ifdef WB_ROUTER_TIMEOUT_EN
        xfer(32'h3000_0010, 1'b0, 32'h0, 4'hF, 0, 32'h0, 1'b0, 20);
        chk("to_lat", x_lat, 32'd6);
        chk("to_dstb", x_dstb, 32'd4);
        chk("to_dat", x_dat, 32'hDEAD_0000);
        finish_xfer("to");
`else
        xfer(32'h3000_0010, 1'b0, 32'h0, 4'hF, 0, 32'h0, 1'b0, 50);
        chk("hang_noack", x_lat, 32'hFFFF_FFFF);
        chk("hang_dstb", x_dstb, 32'd50);
        cyc = 1'b0; stb = 1'b0;
        tick();
        chk("hang_rel", {30'd0, d_stb, ack}, 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
